comp_history_window: RTL

//  Parametrised circular history/lookahead buffer for the LZRW1 compressor front end.
//  - Accepts IN_BYTES-wide beats from the input stream.
//  - Presents the current WIN_BYTES lookahead window, the 3-byte hash key, and a

---
 rtl/comp_pkg.sv | 22 ++
 rtl/comp_hist_ram.sv | 53 +++++
 rtl/comp_history_window.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// ============================================================================
// Module      : comp_pkg
// Description : Shared types, constants and helpers for the LZRW1 history window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package comp_pkg;

    typedef logic [7:0] byte_t;

    localparam int MIN_MATCH = 3;
    localparam int HASH_W    = 24;

    // Lengths shorter than a usable match still consume one literal byte.
    function automatic int unsigned next_step(input int unsigned len);
        return (len < MIN_MATCH) ? 32'd1 : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/comp_hist_ram.sv
// ============================================================================
// Module      : comp_hist_ram
// Description : Byte-addressable circular history storage, one byte-enabled
//               IN_BYTES write port and two WIN_BYTES combinational read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp_hist_ram
    import comp_pkg::*;
#(
    parameter int HIST_DEPTH = 4096,
    parameter int IN_BYTES   = 16,
    parameter int WIN_BYTES  = 16,
    parameter int AW         = $clog2(HIST_DEPTH),
    parameter int NB_W       = $clog2(IN_BYTES) + 1
) (
    input  logic                   clock,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [IN_BYTES*8-1:0]  wr_data,
    input  logic [NB_W-1:0]        wr_nbytes,
    input  logic [AW-1:0]          rd_addr_a,
    output logic [WIN_BYTES*8-1:0] rd_data_a,
    input  logic [AW-1:0]          rd_addr_b,
    output logic [WIN_BYTES*8-1:0] rd_data_b
);

    byte_t mem [HIST_DEPTH];

    // Only the valid low bytes are written so the oldest history is never clobbered.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < IN_BYTES; i++) begin
                if (NB_W'(i) < wr_nbytes) begin
                    mem[wr_addr + AW'(i)] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            rd_data_a[i*8 +: 8] = mem[rd_addr_a + AW'(i)];
            rd_data_b[i*8 +: 8] = mem[rd_addr_b + AW'(i)];
        end
    end

endmodule

`default_nettype wire

// File: rtl/comp_history_window.sv
// ============================================================================
// Module      : comp_history_window
// Description : Circular history/lookahead window for the LZRW1 front end.
//               Optional statistics counters enabled by COMP_HIST_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp_history_window
    import comp_pkg::*;
#(
    parameter int HIST_DEPTH = 4096,
    parameter int IN_BYTES   = 16,
    parameter int WIN_BYTES  = 16,
    parameter int LOOK_MAX   = 64,
    parameter int LEN_W      = 4,
    parameter int DIST_W     = $clog2(HIST_DEPTH)
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IN_BYTES*8-1:0]            in_data,
    input  logic [$clog2(IN_BYTES):0]        in_nbytes,
    input  logic                             in_last,
    output logic                             win_valid,
    output logic [WIN_BYTES*8-1:0]           cur_bytes,
    output logic [$clog2(WIN_BYTES):0]       cur_avail,
    output logic                             hash_valid,
    output logic [HASH_W-1:0]                hash_key,
    input  logic [DIST_W-1:0]                cmp_dist,
    output logic                             cmp_valid,
    output logic [WIN_BYTES*8-1:0]           cmp_bytes,
    input  logic                             adv_valid,
    input  logic [LEN_W-1:0]                 adv_len,
    output logic [31:0]                      byte_ptr,
    output logic                             done
`ifdef COMP_HIST_STATS_EN
    ,
    output logic [31:0]                      stat_bytes_in,
    output logic [31:0]                      stat_stall_cyc,
    output logic [31:0]                      stat_matches
`endif
);

    localparam int PTR_W = DIST_W + 1;
    localparam int NB_W  = $clog2(IN_BYTES) + 1;
    localparam int AV_W  = $clog2(WIN_BYTES) + 1;
    localparam logic [PTR_W-1:0] HIST_MAX = PTR_W'(HIST_DEPTH - LOOK_MAX);
    localparam logic [PTR_W-1:0] ROOM_LIM = PTR_W'(LOOK_MAX - IN_BYTES);

    logic [PTR_W-1:0] wr_ptr, rd_ptr, hist_cnt, lookahead, hist_sum, hist_next;
    logic             last_seen, accept, restart, do_adv;
    logic [AV_W-1:0]  step_req, step;
    logic [WIN_BYTES*8-1:0] win_raw, cmp_raw;

    assign lookahead = wr_ptr - rd_ptr;
    // A finished stream (done) reopens the input so the next stream can restart it.
    assign in_ready  = (lookahead <= ROOM_LIM) && (!last_seen || done);
    assign accept    = in_valid && in_ready;
    assign restart   = accept && done;
    assign win_valid = (lookahead != '0);
    assign do_adv    = adv_valid && win_valid;
    assign cur_avail = (lookahead >= PTR_W'(WIN_BYTES)) ? AV_W'(WIN_BYTES) : lookahead[AV_W-1:0];
    assign step_req  = AV_W'(next_step(32'(adv_len)));
    assign step      = (step_req > cur_avail) ? cur_avail : step_req;
    assign hist_sum  = hist_cnt + PTR_W'(step);
    assign hist_next = (hist_sum > HIST_MAX) ? HIST_MAX : hist_sum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hist_cnt  <= '0;
            byte_ptr  <= '0;
            last_seen <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr    <= wr_ptr + PTR_W'(in_nbytes);
                last_seen <= in_last;
            end
            if (do_adv) begin
                rd_ptr <= rd_ptr + PTR_W'(step);
            end
            if (restart) begin
                hist_cnt <= '0;
                byte_ptr <= '0;
                done     <= 1'b0;
            end else begin
                if (do_adv) begin
                    hist_cnt <= hist_next;
                    byte_ptr <= byte_ptr + 32'(step);
                end
                if (last_seen && (lookahead == '0)) begin
                    done <= 1'b1;
                end
            end
        end
    end

    comp_hist_ram #(
        .HIST_DEPTH (HIST_DEPTH),
        .IN_BYTES   (IN_BYTES),
        .WIN_BYTES  (WIN_BYTES),
        .AW         (DIST_W),
        .NB_W       (NB_W)
    ) u_ram (
        .clock      (clock),
        .wr_en      (accept),
        .wr_addr    (wr_ptr[DIST_W-1:0]),
        .wr_data    (in_data),
        .wr_nbytes  (in_nbytes),
        .rd_addr_a  (rd_ptr[DIST_W-1:0]),
        .rd_data_a  (win_raw),
        .rd_addr_b  (rd_ptr[DIST_W-1:0] - cmp_dist),
        .rd_data_b  (cmp_raw)
    );

    assign hash_valid = (lookahead >= PTR_W'(MIN_MATCH));
    assign hash_key   = hash_valid ? {win_raw[7:0], win_raw[15:8], win_raw[23:16]} : '0;
    assign cmp_valid  = (cmp_dist != '0) && (PTR_W'(cmp_dist) <= hist_cnt);

    always_comb begin
        cur_bytes = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            if (PTR_W'(i) < lookahead) begin
                cur_bytes[i*8 +: 8] = win_raw[i*8 +: 8];
            end
        end
    end

    // Overlapping references replicate the first cmp_dist bytes: byte i maps to i mod dist.
    always_comb begin
        int j;
        j = 0;
        cmp_bytes = '0;
        if (cmp_valid) begin
            for (int i = 0; i < WIN_BYTES; i++) begin
                j = i;
                for (int k = 0; k < WIN_BYTES; k++) begin
                    if (j >= int'(cmp_dist)) begin
                        j = j - int'(cmp_dist);
                    end
                end
                cmp_bytes[i*8 +: 8] = cmp_raw[j*8 +: 8];
            end
        end
    end

`ifdef COMP_HIST_STATS_EN
    logic [32:0] bytes_sum;
    logic        match_adv;

    assign bytes_sum = {1'b0, stat_bytes_in} + 33'(in_nbytes);
    assign match_adv = do_adv && (32'(adv_len) >= 32'(MIN_MATCH));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_bytes_in  <= '0;
            stat_stall_cyc <= '0;
            stat_matches   <= '0;
        end else begin
            if (accept) begin
                stat_bytes_in <= bytes_sum[32] ? '1 : bytes_sum[31:0];
            end
            if (in_valid && !in_ready && (stat_stall_cyc != '1)) begin
                stat_stall_cyc <= stat_stall_cyc + 32'd1;
            end
            if (match_adv && (stat_matches != '1)) begin
                stat_matches <= stat_matches + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
